reg_merge_sched: RTL
====================

Name: reg_merge_sched

Overview:
- Scheduler that shares one WIDTH-bit state register among NREQ requesters.
- Each requester submits a masked write (data plus bit-mask) through a valid/ready handshake into its own one-entry slot.
- Each commit cycle folds every pending write into the register in a fixed order: the higher index wins on overlapping bits, matching last-assignment-wins NBA semantics.
- Sits in front of wide shared control/status registers written by several agents in the same cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 128, register width in bits.
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester write valid.
- req_ready  output  NREQ  per-requester slot can accept.
- req_data  input  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_mask  input  NREQ*WIDTH  per-bit write enable; same packing as req_data.
- hold  input  1  stalls commit; slots keep their contents.
- q  output  WIDTH  committed register value.
- upd  output  1  one-cycle pulse on the cycle after a commit.
- commit_cnt  output  32  number of commits; wraps modulo 2^32.
- conflict_cnt  output  16  see Optional Feature.

Behaviour:
- Reset (async assert, sync deassert internally): q=RESET_VAL, all slots empty, upd=0, commit_cnt=0, conflict_cnt=0.
  - req_ready is all ones from the first clk edge after deassert.
- Slot i
  - States: EMPTY, FULL.
  - Accepts when req_valid[i] && req_ready[i].
  - EMPTY->FULL on accept.
  - FULL->EMPTY on commit with no simultaneous accept.
  - FULL->FULL on commit with simultaneous accept: the new write is captured and the old one is drained.
- req_ready[i] = !full[i] || commit. Combinational from slot state and hold only, never from req_valid.
- commit = (any slot FULL) && !hold.
- On commit:
  - Start from t = q.
  - For i = 0..NREQ-1 ascending: t = (t & ~mask_i) | (data_i & mask_i), for FULL slots only.
  - q <= t.
  - Data bits outside the mask are ignored.
  - A FULL slot with an all-zero mask still counts as a commit; q is unchanged.
- Latency:
  - Write accepted at edge N is visible on q after edge N+1 if hold is low at N+1.
  - Otherwise it is visible after the first edge with hold low.
- upd is registered: it equals 1 in the cycle after the edge at which a commit occurred.
- commit_cnt increments by 1 per commit cycle, not per requester.
- A request is never dropped and never merged twice.
- Writes accepted in the same cycle as a commit belong to the next commit. They never join the current one.
- Reset mid-operation: pending slots are discarded and q returns to RESET_VAL.

Optional Feature:
- Macro: REG_MERGE_CONFLICT_CNT_EN.
- Defined:
  - On each commit, if any two FULL slots' masks overlap (bitwise AND non-zero), conflict_cnt increments by 1.
  - conflict_cnt saturates at 16'hFFFF.
- Undefined:
  - conflict_cnt is tied to 0.
  - No overlap logic is synthesised.
  - The port remains present.

Decomposition:
- Package reg_merge_pkg:
  - DEF_NREQ=4, DEF_WIDTH=128.
  - CNT_W=32, CONF_W=16.
  - typedef logic [DEF_WIDTH-1:0] word_t.
  - Slot state enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module reg_merge_slot, one instance per requester:
  - Holds data/mask and state.
  - Produces full and ready.
  - Inputs: valid, commit.

Test Plan:
- Single cycle, req0: data all-ones, mask all-ones; req3: data 0, mask bit127 only -> one commit, q=7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, commit_cnt=1; conflict_cnt=1 with macro, 0 without.
- Only req1: data 0xA5 repeated, mask low 64 bits -> upper 64 bits keep RESET_VAL, lower 64 = A5A5..A5, upd high exactly one cycle.
- hold=1 for 5 cycles with req2 pending, req2 valid again -> req_ready[2]=0 throughout, q unchanged; on hold release q updates next edge, then the second write is accepted.
- Back-to-back req0 valid every cycle, incrementing data, full mask, hold=0 -> req_ready[0] stays 1, one commit per cycle, q lags accepted data by one edge, commit_cnt counts 10 after 10 writes.
- Assert rst_n=0 asynchronously mid-cycle with slots 0 and 2 FULL -> q=RESET_VAL immediately, after release no commit occurs, commit_cnt=0.
- Preload commit_cnt near 2^32-1 via 2^32 commits in a forced/short-run variant, or check wrap by force -> rolls to 0; conflict_cnt forced to FFFF plus one overlap commit -> stays FFFF.

Source files
------------

// File: rtl/reg_merge_pkg.sv
// Shared types and constants for the merged-write register scheduler.
package reg_merge_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 128;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned CONF_W    = 16;

  typedef logic [DEF_WIDTH-1:0] word_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/reg_merge_slot.sv
// One-entry holding slot for a single requester's masked write.
module reg_merge_slot
  import reg_merge_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             commit,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  output logic             full,
  output logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] mask
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, mask_q;
  logic             accept;

  // A commit drains this slot in the same edge, so a new write can land behind it.
  assign ready  = (state_q == SLOT_EMPTY) || commit;
  assign accept = valid && ready;
  assign full   = (state_q == SLOT_FULL);
  assign data   = data_q;
  assign mask   = mask_q;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = SLOT_FULL;
    end else if (commit) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= wdata;
        mask_q <= wmask;
      end
    end
  end

endmodule

// File: rtl/reg_merge_sched.sv
// Shared WIDTH-bit register folding per-requester masked writes, higher index wins.
// Optional overlap counter enabled by defining REG_MERGE_CONFLICT_CNT_EN.
module reg_merge_sched
  import reg_merge_pkg::*;
#(
  parameter int unsigned      NREQ      = DEF_NREQ,
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic                  hold,
  output logic [WIDTH-1:0]      q,
  output logic                  upd,
  output logic [CNT_W-1:0]      commit_cnt,
  output logic [CONF_W-1:0]     conflict_cnt
);

  logic [NREQ-1:0]            slot_full, slot_ready, slot_valid;
  logic [NREQ-1:0][WIDTH-1:0] slot_data, slot_mask;
  logic [WIDTH-1:0]           q_q, merged;
  logic [CNT_W-1:0]           commit_cnt_q;
  logic                       upd_q, ready_en_q, commit;

  // Acceptance opens on the first edge after reset release (synchronous deassert).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  assign commit     = (|slot_full) && !hold;
  assign slot_valid = req_valid & {NREQ{ready_en_q}};
  assign req_ready  = slot_ready & {NREQ{ready_en_q}};

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    reg_merge_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (slot_valid[i]),
      .commit(commit),
      .wdata (req_data[i*WIDTH +: WIDTH]),
      .wmask (req_mask[i*WIDTH +: WIDTH]),
      .full  (slot_full[i]),
      .ready (slot_ready[i]),
      .data  (slot_data[i]),
      .mask  (slot_mask[i])
    );
  end

  // Ascending fold gives last-assignment-wins priority to the highest index.
  always_comb begin
    merged = q_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (slot_full[i]) begin
        merged = (merged & ~slot_mask[i]) | (slot_data[i] & slot_mask[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= RESET_VAL;
      upd_q        <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      upd_q <= commit;
      if (commit) begin
        q_q          <= merged;
        commit_cnt_q <= commit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign q          = q_q;
  assign upd        = upd_q;
  assign commit_cnt = commit_cnt_q;

`ifdef REG_MERGE_CONFLICT_CNT_EN
  logic [CONF_W-1:0] conflict_q;
  logic              overlap;

  always_comb begin
    overlap = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = i + 1; j < NREQ; j++) begin
        if (slot_full[i] && slot_full[j] && (|(slot_mask[i] & slot_mask[j]))) begin
          overlap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (commit && overlap && (conflict_q != {CONF_W{1'b1}})) begin
      conflict_q <= conflict_q + CONF_W'(1);
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
